// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, bubble encoding, halt opcode and
// the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [3:0]         opcode_t;

    localparam instr_t  NOP_INSTR  = 16'h0000;
    localparam opcode_t HLT_OPCODE = 4'hF;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    function automatic opcode_t opcode_of(input instr_t instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and IM (slave).
interface if_fetch_stage_if
    import cpu_pkg::*;
();

    addr_t  im_addr;
    logic   im_rd_en;
    instr_t im_instr;

    modport master (
        output im_addr,
        output im_rd_en,
        input  im_instr
    );

    modport slave (
        input  im_addr,
        input  im_rd_en,
        output im_instr
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and beats enable, so a
// redirect always squashes even while the hazard unit is stalling.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter instr_t NOP = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    input  logic   flush_i,
    input  instr_t instr_i,
    input  addr_t  pc_plus1_i,
    output instr_t instr_o,
    output addr_t  pc_plus1_o,
    output logic   valid_o
);

    instr_t instr_q;
    addr_t  pc_plus1_q;
    logic   valid_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // every state update uses <= to avoid ordering races between flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (en_i) begin
            instr_q    <= instr_i;
            pc_plus1_q <= pc_plus1_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, drives the IM read port and feeds IF/ID.
// Priority each cycle: reset > redirect > stall > halt-detect > normal.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter addr_t   RESET_PC   = 16'h0000,
    parameter instr_t  NOP_INSTR  = cpu_pkg::NOP_INSTR,
    parameter opcode_t HLT_OPCODE = cpu_pkg::HLT_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if_i,
    input  logic              branch_taken_i,
    input  addr_t             branch_target_i,
    if_fetch_stage_if.master  im,
    output instr_t            if_id_instr_o,
    output addr_t             if_id_pc_plus1_o,
    output logic              if_id_valid_o,
    output logic              halted_o
);

    fetch_state_e state_q;
    addr_t        pc_q;
    addr_t        pc_plus1;
    logic         hlt_seen;

    assign pc_plus1 = addr_t'(pc_q + 1'b1);
    assign hlt_seen = (opcode_of(im.im_instr) == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH_RUN;
        end else if (branch_taken_i) begin
            pc_q    <= branch_target_i;
            state_q <= FETCH_RUN;
        end else if (!stall_if_i) begin
            case (state_q)
                FETCH_RUN: begin
                    // The HLT itself still enters IF/ID; only the PC freezes.
                    if (hlt_seen) state_q <= FETCH_HALT;
                    else          pc_q    <= pc_plus1;
                end
                FETCH_HALT: ;
                default:    state_q <= FETCH_RUN;
            endcase
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (!stall_if_i),
        .flush_i    (branch_taken_i | ((state_q == FETCH_HALT) & !stall_if_i)),
        .instr_i    (im.im_instr),
        .pc_plus1_i (pc_plus1),
        .instr_o    (if_id_instr_o),
        .pc_plus1_o (if_id_pc_plus1_o),
        .valid_o    (if_id_valid_o)
    );

    assign im.im_addr  = pc_q;
    assign im.im_rd_en = rst_n & (state_q != FETCH_HALT);
    assign halted_o    = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage with a small behavioural IM:
// word 3 holds HLT (16'hF000), every other word reads as {4'h1, addr[11:0]}.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  stall_if;
    logic  branch_taken;
    addr_t branch_target;
    instr_t if_id_instr;
    addr_t  if_id_pc_plus1;
    logic   if_id_valid;
    logic   halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if im_bus ();

    assign im_bus.im_instr = (im_bus.im_addr == 16'd3) ? 16'hF000
                                                        : {4'h1, im_bus.im_addr[11:0]};

    if_fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_if_i       (stall_if),
        .branch_taken_i   (branch_taken),
        .branch_target_i  (branch_target),
        .im               (im_bus.master),
        .if_id_instr_o    (if_id_instr),
        .if_id_pc_plus1_o (if_id_pc_plus1),
        .if_id_valid_o    (if_id_valid),
        .halted_o         (halted)
    );

    typedef struct {
        logic   rst_n;
        logic   stall;
        logic   br;
        addr_t  tgt;
        addr_t  e_addr;
        logic   e_rd_en;
        instr_t e_instr;
        addr_t  e_pc1;
        logic   e_valid;
        logic   e_halted;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic s, logic b, addr_t t, addr_t a, logic re,
                                instr_t ins, addr_t p1, logic v, logic h);
        vec_t x;
        x.rst_n = r;  x.stall = s;  x.br = b;  x.tgt = t;
        x.e_addr = a; x.e_rd_en = re; x.e_instr = ins; x.e_pc1 = p1;
        x.e_valid = v; x.e_halted = h;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input addr_t a, input logic re, input instr_t ins,
                             input addr_t p1, input logic v, input logic h);
        check({tag, ".im_addr"},  32'(im_bus.im_addr),  32'(a));
        check({tag, ".im_rd_en"}, 32'(im_bus.im_rd_en), 32'(re));
        check({tag, ".instr"},    32'(if_id_instr),     32'(ins));
        check({tag, ".pc_plus1"}, 32'(if_id_pc_plus1),  32'(p1));
        check({tag, ".valid"},    32'(if_id_valid),     32'(v));
        check({tag, ".halted"},   32'(halted),          32'(h));
    endtask

    initial begin
        //            rst s  b  tgt       addr      re instr     pc1       v  h
        vecs[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // reset x3
        vecs[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[3]  = mk(1, 0, 0, 16'h0000, 16'h0001, 1, 16'h1000, 16'h0001, 1, 0); // first fetch
        vecs[4]  = mk(1, 0, 0, 16'h0000, 16'h0002, 1, 16'h1001, 16'h0002, 1, 0);
        vecs[5]  = mk(1, 0, 1, 16'h0004, 16'h0004, 1, 16'h0000, 16'h0000, 0, 0); // redirect to 4
        vecs[6]  = mk(1, 0, 0, 16'h0000, 16'h0005, 1, 16'h1004, 16'h0005, 1, 0);
        vecs[7]  = mk(1, 1, 0, 16'h0000, 16'h0005, 1, 16'h1004, 16'h0005, 1, 0); // stall at 5
        vecs[8]  = mk(1, 1, 0, 16'h0000, 16'h0005, 1, 16'h1004, 16'h0005, 1, 0);
        vecs[9]  = mk(1, 0, 0, 16'h0000, 16'h0006, 1, 16'h1005, 16'h0006, 1, 0);
        vecs[10] = mk(1, 1, 1, 16'h0040, 16'h0040, 1, 16'h0000, 16'h0000, 0, 0); // redirect beats stall
        vecs[11] = mk(1, 0, 0, 16'h0000, 16'h0041, 1, 16'h1040, 16'h0041, 1, 0);
        vecs[12] = mk(1, 0, 1, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[13] = mk(1, 0, 0, 16'h0000, 16'h0001, 1, 16'h1000, 16'h0001, 1, 0);
        vecs[14] = mk(1, 0, 0, 16'h0000, 16'h0002, 1, 16'h1001, 16'h0002, 1, 0);
        vecs[15] = mk(1, 0, 0, 16'h0000, 16'h0003, 1, 16'h1002, 16'h0003, 1, 0);
        vecs[16] = mk(1, 0, 0, 16'h0000, 16'h0003, 0, 16'hF000, 16'h0004, 1, 1); // HLT at 3
        vecs[17] = mk(1, 1, 0, 16'h0000, 16'h0003, 0, 16'hF000, 16'h0004, 1, 1); // stall while halted
        vecs[18] = mk(1, 0, 0, 16'h0000, 16'h0003, 0, 16'h0000, 16'h0000, 0, 1);
        vecs[19] = mk(1, 0, 0, 16'h0000, 16'h0003, 0, 16'h0000, 16'h0000, 0, 1);
        vecs[20] = mk(1, 0, 1, 16'h0008, 16'h0008, 1, 16'h0000, 16'h0000, 0, 0); // exit halt
        vecs[21] = mk(1, 0, 0, 16'h0000, 16'h0009, 1, 16'h1008, 16'h0009, 1, 0);
        vecs[22] = mk(1, 0, 1, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0000, 0, 0); // wrap
        vecs[23] = mk(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h1FFF, 16'h0000, 1, 0);
        vecs[24] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // reset beats stall
        vecs[25] = mk(1, 0, 0, 16'h0000, 16'h0001, 1, 16'h1000, 16'h0001, 1, 0);

        rst_n = 1'b0; stall_if = 1'b0; branch_taken = 1'b0; branch_target = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            stall_if      = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_rd_en, vecs[i].e_instr,
                      vecs[i].e_pc1, vecs[i].e_valid, vecs[i].e_halted);
        end

        // Reset pulse while halted: fetch must restart from the reset PC.
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 16'h0003;
        @(negedge clk);
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        check_all("mh_halt", 16'h0003, 1'b0, 16'hF000, 16'h0004, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mh_rd_en_in_reset", 32'(im_bus.im_rd_en), 32'd0);
        @(posedge clk);
        #1;
        check_all("mh_reset", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("mh_restart", 16'h0001, 1'b1, 16'h1000, 16'h0001, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
